// File: rtl/palgen_pkg.sv
// Shared types and helpers for the palindrome pattern generator.
`timescale 1ns/1ps
package palgen_pkg;

    // Widest supported half-word; helpers operate at this width.
    localparam int unsigned MAX_HALF = 8;

    // Word source selected at burst start (2'b11 folds onto FIXED).
    typedef enum logic [1:0] {
        COUNT = 2'b00,
        LFSR  = 2'b01,
        FIXED = 2'b10
    } mode_e;

    // Burst control states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Maximal-length Galois tap masks (right-shifting form) indexed by half width.
    function automatic logic [MAX_HALF-1:0] lfsr_taps(input int unsigned half);
        logic [MAX_HALF-1:0] taps;
        case (half)
            2:       taps = 8'h03;
            3:       taps = 8'h06;
            4:       taps = 8'h0C;
            5:       taps = 8'h14;
            6:       taps = 8'h30;
            7:       taps = 8'h60;
            default: taps = 8'hB8;
        endcase
        return taps;
    endfunction

    // Reverse the low n bits of v; bits at and above n must be zero on entry.
    function automatic logic [MAX_HALF-1:0] bitrev(input logic [MAX_HALF-1:0] v,
                                                   input int unsigned n);
        logic [MAX_HALF-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_HALF); i++) begin
            r[i] = v[MAX_HALF-1-i];
        end
        return r >> (MAX_HALF - n);
    endfunction

endpackage

// File: rtl/palgen_lfsr.sv
// HALF-bit Galois LFSR with load and advance enables; exposes its next state.
`timescale 1ns/1ps
module palgen_lfsr
    import palgen_pkg::*;
#(
    parameter int unsigned HALF = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            advance,
    input  logic [HALF-1:0] seed,
    output logic [HALF-1:0] next_c
);

    localparam logic [HALF-1:0] TAPS = HALF'(lfsr_taps(HALF));

    logic [HALF-1:0] state_q;

    // One Galois step: shift right, fold taps in when the dropped bit is set.
    always_comb begin
        next_c = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end

    // State register; a zero load is replaced by 1 so the register never locks up.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= (seed == '0) ? HALF'(1) : seed;
        end else if (advance) begin
            state_q <= next_c;
        end
    end

endmodule

// File: rtl/palindrome_pattern_gen.sv
// Streams palindromic words {half, bitrev(half)} over valid/ready.
// Optional feature macro: PALGEN_ERR_INJECT_EN (periodic bit-0 corruption with err_flag).
`timescale 1ns/1ps
module palindrome_pattern_gen
    import palgen_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned HALF  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [HALF-1:0]  seed,
    input  logic [7:0]       count_len,
    input  logic             out_ready,
`ifdef PALGEN_ERR_INJECT_EN
    input  logic [7:0]       err_period,
    output logic [0:0]       err_flag,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [HALF-1:0]  half_q, half_d;
    logic [7:0]       remaining_q, remaining_d;
    logic             valid_d, busy_d, done_d;
    logic [WIDTH-1:0] data_d;

    logic             transfer_c;
    mode_e            start_mode_c;
    logic [HALF-1:0]  seed_eff_c;
    logic [HALF-1:0]  half_next_c;
    logic [HALF-1:0]  lfsr_next_c;
    logic             lfsr_load_c, lfsr_adv_c;
    logic             word_load_c, word_first_c;

`ifdef PALGEN_ERR_INJECT_EN
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             err_flag_d;
`endif

    // Mirror the upper half into the lower half.
    function automatic logic [WIDTH-1:0] make_word(input logic [HALF-1:0] h);
        return {h, HALF'(bitrev(MAX_HALF'(h), HALF))};
    endfunction

    palgen_lfsr #(
        .HALF    (HALF)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load_c),
        .advance (lfsr_adv_c),
        .seed    (seed_eff_c),
        .next_c  (lfsr_next_c)
    );

    // Handshake, start-time mode folding and the per-mode next upper half.
    always_comb begin
        transfer_c   = out_valid & out_ready;
        start_mode_c = (mode == 2'b11) ? FIXED : mode_e'(mode);
        seed_eff_c   = ((start_mode_c == LFSR) && (seed == '0)) ? HALF'(1) : seed;
        case (mode_q)
            COUNT:   half_next_c = half_q + 1'b1;
            LFSR:    half_next_c = lfsr_next_c;
            default: half_next_c = half_q;
        endcase
    end

    // Next-state and next-output logic for the burst FSM.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        half_d       = half_q;
        remaining_d  = remaining_q;
        valid_d      = out_valid;
        busy_d       = busy;
        done_d       = 1'b0;
        lfsr_load_c  = 1'b0;
        lfsr_adv_c   = 1'b0;
        word_load_c  = 1'b0;
        word_first_c = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d      = RUN;
                    mode_d       = start_mode_c;
                    half_d       = seed_eff_c;
                    remaining_d  = count_len;
                    valid_d      = 1'b1;
                    busy_d       = 1'b1;
                    lfsr_load_c  = 1'b1;
                    word_load_c  = 1'b1;
                    word_first_c = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort wins over a same-cycle transfer and suppresses done.
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (transfer_c) begin
                    if (remaining_q == 8'd1) begin
                        state_d     = DONE;
                        remaining_d = 8'd0;
                        valid_d     = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        // remaining==0 marks a continuous burst and is never decremented.
                        if (remaining_q != 8'd0) begin
                            remaining_d = remaining_q - 8'd1;
                        end
                        half_d      = half_next_c;
                        lfsr_adv_c  = (mode_q == LFSR);
                        word_load_c = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

`ifdef PALGEN_ERR_INJECT_EN
        // Track the 1-based word position modulo err_period; flag the word that lands on it.
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag[0];
        if (word_load_c) begin
            if (word_first_c || (err_cnt_q >= err_period)) begin
                err_cnt_d = 8'd1;
            end else begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            err_flag_d = (err_period != 8'd0) && (err_cnt_d == err_period);
        end
        if (!valid_d) begin
            err_flag_d = 1'b0;
        end
        data_d = word_load_c ? (make_word(half_d) ^ WIDTH'(err_flag_d)) : out_data;
`else
        data_d = word_load_c ? make_word(half_d) : out_data;
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= COUNT;
            half_q      <= '0;
            remaining_q <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            half_q      <= half_d;
            remaining_q <= remaining_d;
            out_valid   <= valid_d;
            out_data    <= data_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

`ifdef PALGEN_ERR_INJECT_EN
    // Injection position counter and its flag output.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_flag  <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_flag  <= err_flag_d;
        end
    end
`endif

endmodule
